// File: rtl/codec_cfg_pkg.sv
// Shared types and the WM8731 power-up register table for the codec configuration sequencer.
package codec_cfg_pkg;

  localparam int CFG_LEN   = 11;
  localparam int MAX_RETRY = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] data;
  } cfg_entry_t;

  // R15 first: writing 0 to it resets the codec before the real settings go in.
  localparam cfg_entry_t CFG_TABLE [CFG_LEN] = '{
    '{7'd15, 9'h000},
    '{7'd0,  9'h017},
    '{7'd1,  9'h017},
    '{7'd2,  9'h079},
    '{7'd3,  9'h079},
    '{7'd4,  9'h012},
    '{7'd5,  9'h000},
    '{7'd6,  9'h000},
    '{7'd7,  9'h002},
    '{7'd8,  9'h000},
    '{7'd9,  9'h001}
  };

  // Byte `sel` (0..2) of the write frame for table entry `e`.
  function automatic logic [7:0] frame_byte(input logic [6:0] dev_addr,
                                            input cfg_entry_t e,
                                            input logic [1:0] sel);
    case (sel)
      2'd0:    frame_byte = {dev_addr, 1'b0};
      2'd1:    frame_byte = {e.reg_addr, e.data[8]};
      default: frame_byte = e.data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/codec_cfg_seq_if.sv
// Control handshake between the audio output block (master) and the codec sequencer (slave).
interface codec_cfg_seq_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] err_idx;

  modport master (output start, input busy, done, error, err_idx);
  modport slave  (input start, output busy, done, error, err_idx);
endinterface

// File: rtl/i2c_bit_tick.sv
// Quarter-phase generator: q_strobe marks the last clk of each quarter, phase counts q0..q3.
module i2c_bit_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  output logic       q_strobe,
  output logic [1:0] phase
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_strobe = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d    = q_strobe ? '0 : cnt_q + 1'b1;
    phase_d  = q_strobe ? phase_q + 2'd1 : phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 2'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/codec_cfg_seq.sv
// WM8731 power-up sequencer: writes the 11-entry table over the 2-wire port and reports busy/done/error.
// Optional feature: define CODEC_CFG_RETRY_EN to retry a NACKed entry up to MAX_RETRY times.
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic            clk,
  input  logic            reset,
  codec_cfg_seq_if.slave  ctl,
  output logic            i2c_sclk,
  inout  wire             i2c_sdat
);

  localparam logic [3:0] LAST_IDX = 4'(CFG_LEN - 1);

  cfg_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic       nack_q, nack_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [3:0] err_idx_q, err_idx_d;
  logic       sclk_q, sclk_d;
  logic       sda_low_q, sda_low_d;
  logic       sda_meta_q, sda_sync_q;
`ifdef CODEC_CFG_RETRY_EN
  logic [1:0] retry_q, retry_d;
`endif

  logic       accept;
  logic       end_bit;
  logic       fatal;
  logic       q_strobe;
  logic [1:0] phase;
  logic [7:0] cur_byte;

  assign accept   = ctl.start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign end_bit  = q_strobe && (phase == 2'd3);
  assign cur_byte = frame_byte(DEV_ADDR, CFG_TABLE[idx_q], byte_q);

  i2c_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .restart  (accept),
    .q_strobe (q_strobe),
    .phase    (phase)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    nack_d    = nack_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
`ifdef CODEC_CFG_RETRY_EN
    retry_d   = retry_q;
    fatal     = (retry_q == 2'(MAX_RETRY));
`else
    fatal     = 1'b1;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (accept) begin
          state_d   = ST_START;
          idx_d     = 4'd0;
          nack_d    = 1'b0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = 4'd0;
`ifdef CODEC_CFG_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end
      ST_START: begin
        if (end_bit) begin
          state_d = ST_BIT;
          byte_d  = 2'd0;
          bit_d   = 3'd7;
        end
      end
      ST_BIT: begin
        if (end_bit) begin
          if (bit_q == 3'd0) state_d = ST_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      ST_ACK: begin
        if (end_bit) begin
          if (sda_sync_q) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else if (byte_q == 2'd2) begin
            state_d = ST_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd7;
            state_d = ST_BIT;
          end
        end
      end
      ST_STOP: begin
        if (end_bit) begin
          if (nack_q && fatal) begin
            state_d   = ST_ERR;
            error_d   = 1'b1;
            err_idx_d = idx_q;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (end_bit) begin
          state_d = ST_START;
`ifdef CODEC_CFG_RETRY_EN
          if (nack_q) begin
            nack_d  = 1'b0;
            retry_d = retry_q + 2'd1;
          end else
`endif
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
`ifdef CODEC_CFG_RETRY_EN
            retry_d = 2'd0;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
  end

  // Bus pins decoded from the current phase and registered, so SCL/SDA never glitch.
  always_comb begin
    sclk_d    = 1'b1;
    sda_low_d = 1'b0;
    case (state_q)
      ST_START: sda_low_d = phase[1];
      ST_BIT: begin
        sclk_d    = phase[1];
        sda_low_d = !cur_byte[bit_q];
      end
      ST_ACK:   sclk_d = phase[1];
      ST_STOP: begin
        sclk_d    = (phase != 2'd0);
        sda_low_d = !phase[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      byte_q     <= 2'd0;
      bit_q      <= 3'd7;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= 4'd0;
      sclk_q     <= 1'b1;
      sda_low_q  <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
`ifdef CODEC_CFG_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      nack_q     <= nack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      sclk_q     <= sclk_d;
      sda_low_q  <= sda_low_d;
      sda_meta_q <= i2c_sdat;
      sda_sync_q <= sda_meta_q;
`ifdef CODEC_CFG_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign i2c_sclk    = sclk_q;
  assign i2c_sdat    = sda_low_q ? 1'b0 : 1'bz;
  assign ctl.busy    = busy_q;
  assign ctl.done    = done_q;
  assign ctl.error   = error_q;
  assign ctl.err_idx = err_idx_q;

endmodule
